prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Instruction-memory responder for the 4-bit core's fetch interface: returns the 8-bit instruction word at the core's 4-bit instruction address.
- Owns a writable 16 x 8 program store, filled through a valid/ready byte-stream load port.
- Sequences the core's synchronous active-low reset so that the core never executes while a load is in progress.
- Sits between the board-level loader/host link and the core.

Parameters:
- ADDR_W, 4, fetch address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, instruction word width (opcode[7:4], immediate[3:0]).

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- addr  in  ADDR_W  fetch address from the core
- data  out  DATA_W  instruction word to the core
- load_start  in  1  single-cycle request to begin a full program load
- run_req  in  1  single-cycle request to release the core without loading
- wr_valid  in  1  load byte valid
- wr_data  in  DATA_W  load byte, delivered in address order 0..DEPTH-1
- wr_ready  out  1  load byte accepted when wr_valid && wr_ready
- cpu_n_reset  out  1  registered reset to the core, active low
- busy  out  1  high while state is LOAD
- load_done  out  1  one-cycle pulse when the core is released after a completed load

Behaviour:
- Reset (n_reset = 0, asynchronous), all cleared:
  - all memory words = 0; state = HALT; wr_ptr = 0
  - cpu_n_reset = 0; wr_ready = 0; busy = 0; load_done = 0
- States:
  - HALT: core held in reset.
    - load_start -> LOAD, with wr_ptr cleared to 0.
    - Else run_req -> RELEASE.
    - load_start wins over run_req when both are asserted.
  - LOAD: wr_ready = 1.
    - Each handshake writes wr_data to mem[wr_ptr] at that clock edge and increments wr_ptr.
    - The handshake at wr_ptr = DEPTH-1 writes the last word, wraps wr_ptr to 0, and goes to RELEASE.
    - wr_valid low stalls indefinitely; no timeout.
    - load_start and run_req are ignored in LOAD.
  - RELEASE: exactly one cycle, core still held in reset, wr_ready = 0. Always goes to RUN.
  - RUN: cpu_n_reset = 1.
    - load_start -> LOAD, with wr_ptr cleared to 0.
    - run_req is ignored.
- cpu_n_reset is a flop, set to 1 exactly when the next state is RUN. It therefore goes low on the same edge that enters LOAD, and the core's synchronous reset samples it low on every LOAD/RELEASE cycle.
- load_done: registered; high for exactly the first RUN cycle when that RUN was entered via LOAD -> RELEASE. It stays low when RUN is entered from HALT via run_req.
- Fetch read path:
  - data = mem[addr], combinational and asynchronous, in all states.
  - In RUN the core sees an instruction in the same cycle it drives addr; zero fetch latency.
  - addr wraps naturally at DEPTH (4-bit); no out-of-range case exists.
- Write/read collision:
  - A write and a read of the same address in the same cycle returns the old word until the edge.
  - This can only occur while the core is in reset, so it has no architectural effect.
- A load never partially updates and then releases. The core is released only after all DEPTH words are written.
- A reset mid-load discards the partial load: memory is cleared to zero and the state returns to HALT.
- Cleared memory decodes as word 0x00 = ADD A,0, which advances the instruction pointer only. Releasing on empty memory is therefore a safe spin.

Test Plan:
- Reset then idle 10 cycles -> cpu_n_reset = 0, wr_ready = 0, data = 0x00 for all addr values 0..15.
- HALT, pulse run_req -> RELEASE one cycle, cpu_n_reset rises on the 2nd edge after the pulse, and load_done stays 0.
- load_start, then stream 0x31, 0x01, …, 0xF0 with wr_valid held high:
  - wr_ready is high for exactly 16 cycles.
  - One RELEASE cycle follows, then cpu_n_reset = 1 and load_done pulses once.
  - Sweeping addr 0..15 returns the loaded bytes in order.
- Load with wr_valid gapped (toggling every other cycle) -> only handshake cycles advance wr_ptr, and the memory contents match the stream exactly.
- While in RUN, pulse load_start -> cpu_n_reset is 0 after the next edge, busy = 1, and reload of 0xB5 x16 is read back as 0xB5 at every addr.
- Assert n_reset after 7 of 16 bytes -> cpu_n_reset = 0, busy = 0, and all words read 0x00 immediately (asynchronous). A subsequent full load completes normally.

Source files
------------

// File: rtl/prog_mem_loader.sv
// Instruction-memory responder for the 4-bit core.
// Holds a writable DEPTH x DATA_W program store that is filled in address order
// through a valid/ready byte stream. It also sequences the core's reset so the
// core never executes while a load is in progress.
module prog_mem_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              load_start,
    input  logic              run_req,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              cpu_n_reset,
    output logic              busy,
    output logic              load_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_HALT    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic              wr_ready_r;
    logic              busy_r;
    logic              cpu_n_reset_r;
    logic              load_done_r;
    logic              from_load_r;
    logic              handshake_s;
    logic              enter_load_s;

    // A byte is accepted only while loading; wr_ready_r is high exactly then.
    assign handshake_s  = wr_valid && wr_ready_r && (state_r == ST_LOAD);
    assign enter_load_s = (state_nxt_s == ST_LOAD) && (state_r != ST_LOAD);

    // Next-state decode; load_start takes priority over run_req in HALT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HALT: begin
                if (load_start) begin
                    state_nxt_s = ST_LOAD;
                end else if (run_req) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_LOAD: begin
                if (handshake_s && (wr_ptr_r == PTR_LAST)) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (load_start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_HALT;
            end
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r       <= ST_HALT;
            wr_ready_r    <= 1'b0;
            busy_r        <= 1'b0;
            cpu_n_reset_r <= 1'b0;
            load_done_r   <= 1'b0;
            from_load_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wr_ready_r    <= (state_nxt_s == ST_LOAD);
            busy_r        <= (state_nxt_s == ST_LOAD);
            cpu_n_reset_r <= (state_nxt_s == ST_RUN);
            // Remember how RELEASE was reached so only a completed load pulses.
            if (state_nxt_s == ST_RELEASE) begin
                from_load_r <= (state_r == ST_LOAD);
            end else begin
                from_load_r <= from_load_r;
            end
            load_done_r   <= (state_r == ST_RELEASE) && from_load_r;
        end
    end

    // Write pointer: cleared on entry to LOAD, advanced per accepted byte.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_r <= '0;
        end else if (enter_load_s) begin
            wr_ptr_r <= '0;
        end else if (handshake_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Program store; reset clears it so an aborted load leaves no partial image.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (handshake_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Zero-latency fetch: old word is returned until a colliding write's edge.
    assign data        = mem_r[addr];
    assign wr_ready    = wr_ready_r;
    assign busy        = busy_r;
    assign cpu_n_reset = cpu_n_reset_r;
    assign load_done   = load_done_r;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized self-checking bench for prog_mem_loader. The reference model is a
// plain array of expected words plus the release sequence expected after a
// complete load or a run request.
module tb_prog_mem_loader;

    logic       clk;
    logic       n_reset;
    logic [3:0] addr;
    logic [7:0] data;
    logic       load_start;
    logic       run_req;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       cpu_n_reset;
    logic       busy;
    logic       load_done;

    int n_total;
    int n_bad;

    logic [7:0] model_mem [16];
    logic [7:0] prog [16];

    prog_mem_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk),
        .n_reset(n_reset),
        .addr(addr),
        .data(data),
        .load_start(load_start),
        .run_req(run_req),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .cpu_n_reset(cpu_n_reset),
        .busy(busy),
        .load_done(load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read every address back and compare with the model.
    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            check(tag, 32'(data), 32'(model_mem[a]));
        end
    endtask

    // mode 0: valid held high, 1: toggling every other cycle, 2: random gaps.
    // both: assert run_req with load_start to exercise priority.
    task automatic load_prog(input int mode, input bit both);
        int idx;
        int ready_cycles;
        int budget;
        bit held_ok;
        load_start = 1'b1;
        run_req    = both;
        step();
        load_start = 1'b0;
        run_req    = 1'b0;
        check("enter_busy", 32'(busy), 32'd1);
        check("enter_core_held", 32'(cpu_n_reset), 32'd0);
        idx = 0;
        ready_cycles = 0;
        budget = 400;
        held_ok = 1'b1;
        while (idx < 16 && budget > 0) begin
            budget--;
            case (mode)
                0:       wr_valid = 1'b1;
                1:       wr_valid = ((budget % 2) == 0);
                default: wr_valid = ($urandom_range(0, 2) != 0);
            endcase
            wr_data    = wr_valid ? prog[idx] : 8'($urandom);
            load_start = 1'($urandom_range(0, 1));
            run_req    = 1'($urandom_range(0, 1));
            addr       = 4'($urandom);
            if (cpu_n_reset !== 1'b0) held_ok = 1'b0;
            if (wr_ready === 1'b1) begin
                ready_cycles++;
                if (wr_valid) begin
                    model_mem[idx] = prog[idx];
                    idx++;
                end
            end
            step();
        end
        load_start = 1'b0;
        run_req    = 1'b0;
        wr_valid   = 1'b0;
        if (budget == 0) check("load_timeout", 32'd0, 32'd1);
        check("load_core_held", 32'(held_ok), 32'd1);
        if (mode == 0) check("ready_cycles", 32'(ready_cycles), 32'd16);
        // RELEASE cycle
        check("rel_ready", 32'(wr_ready), 32'd0);
        check("rel_core_held", 32'(cpu_n_reset), 32'd0);
        check("rel_done", 32'(load_done), 32'd0);
        step();
        check("run_core", 32'(cpu_n_reset), 32'd1);
        check("run_done_pulse", 32'(load_done), 32'd1);
        check("run_busy", 32'(busy), 32'd0);
        step();
        check("run_done_end", 32'(load_done), 32'd0);
        sweep("readback");
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        n_reset    = 1'b0;
        addr       = 4'd0;
        load_start = 1'b0;
        run_req    = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 8'd0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

        repeat (3) step();
        check("rst_core", 32'(cpu_n_reset), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        n_reset = 1'b1;
        repeat (10) step();
        check("idle_core", 32'(cpu_n_reset), 32'd0);
        check("idle_ready", 32'(wr_ready), 32'd0);
        sweep("idle_data");

        // Release without loading.
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("runreq_rel_core", 32'(cpu_n_reset), 32'd0);
        check("runreq_rel_done", 32'(load_done), 32'd0);
        step();
        check("runreq_run_core", 32'(cpu_n_reset), 32'd1);
        check("runreq_no_done", 32'(load_done), 32'd0);
        step();
        check("runreq_no_done2", 32'(load_done), 32'd0);
        // run_req in RUN is ignored.
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        step();
        check("runreq_ignored", 32'(cpu_n_reset), 32'd1);

        // Full load from RUN, valid held high, stream 0x31, ..., 0xF0.
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        prog[0]  = 8'h31;
        prog[1]  = 8'h01;
        prog[15] = 8'hF0;
        load_prog(0, 1'b0);

        // Gapped load, valid toggling.
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        load_prog(1, 1'b0);

        // Reload of a constant image.
        for (int i = 0; i < 16; i++) prog[i] = 8'hB5;
        load_prog(2, 1'b0);

        // Reset after 7 of 16 bytes.
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = prog[i];
            step();
        end
        wr_valid = 1'b0;
        #2;
        n_reset = 1'b0;
        #1;
        check("abort_core", 32'(cpu_n_reset), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        sweep("abort_data");
        step();
        n_reset = 1'b1;
        step();
        check("abort_halt_core", 32'(cpu_n_reset), 32'd0);

        // Full load from HALT with load_start and run_req together.
        load_prog(2, 1'b1);

        // Random fetches in RUN.
        for (int k = 0; k < 20; k++) begin
            addr = 4'($urandom);
            #1;
            check("rand_fetch", 32'(data), 32'(model_mem[addr]));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
